trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_pkg.sv | 27 ++
 rtl/trap_ctrl_if.sv | 26 ++
 rtl/trap_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Trap controller shared types: FSM states, CSR map, mstatus bits, causes.
// Imported by the trap controller and anything driving its CSR port.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    T_EPC,
    T_CAUSE,
    T_STATUS,
    T_VEC,
    R_STATUS,
    R_EPC
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h000;
  localparam logic [11:0] CSR_MTVEC   = 12'h005;
  localparam logic [11:0] CSR_MEPC    = 12'h041;
  localparam logic [11:0] CSR_MCAUSE  = 12'h042;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR register-file port shared by the trap controller and the CSR file.
// The controller is master; the CSR file answers with combinational rdata.
interface trap_ctrl_if #(
  parameter int XLEN = 32
);

  logic            csr_w;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;

  modport master (
    output csr_w,
    output csr_addr,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_w,
    input  csr_addr,
    input  csr_wdata,
    output csr_rdata
  );

endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer driving the CSR file and PC.
// Owns the CSR port outside IDLE; passes core CSR writes through in IDLE.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  input  logic            core_csr_w,
  input  logic [11:0]     core_csr_addr,
  input  logic [XLEN-1:0] core_csr_wdata,
  trap_ctrl_if.master     csr,
  output logic            stall,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_target
);

  state_t          state;
  logic [XLEN-1:0] epc_q;
  logic [3:0]      cause_q;
  logic [XLEN-1:0] status;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trap_req) begin
            state   <= T_EPC;
            epc_q   <= trap_pc;
            cause_q <= trap_cause;
          end else if (mret_req) begin
            state <= R_STATUS;
          end
        end
        T_EPC:    state <= T_CAUSE;
        T_CAUSE:  state <= T_STATUS;
        T_STATUS: state <= T_VEC;
        T_VEC:    state <= IDLE;
        R_STATUS: state <= R_EPC;
        R_EPC:    state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign stall = (state != IDLE) | trap_req | mret_req;

  always_comb begin
    csr.csr_w     = 1'b0;
    csr.csr_addr  = '0;
    csr.csr_wdata = '0;
    pc_load       = 1'b0;
    pc_target     = '0;
    status        = csr.csr_rdata;
    unique case (state)
      IDLE: begin
        // an accepted trap/mret owns the CSR file from here on
        csr.csr_w     = core_csr_w & ~(trap_req | mret_req);
        csr.csr_addr  = core_csr_addr;
        csr.csr_wdata = core_csr_wdata;
      end
      T_EPC: begin
        csr.csr_w     = 1'b1;
        csr.csr_addr  = CSR_MEPC;
        csr.csr_wdata = epc_q;
      end
      T_CAUSE: begin
        csr.csr_w     = 1'b1;
        csr.csr_addr  = CSR_MCAUSE;
        csr.csr_wdata = {{(XLEN-4){1'b0}}, cause_q};
      end
      T_STATUS: begin
        status[MPIE_BIT] = csr.csr_rdata[MIE_BIT];
        status[MIE_BIT]  = 1'b0;
        csr.csr_w     = 1'b1;
        csr.csr_addr  = CSR_MSTATUS;
        csr.csr_wdata = status;
      end
      T_VEC: begin
        csr.csr_addr = CSR_MTVEC;
        pc_load      = 1'b1;
        pc_target    = {csr.csr_rdata[XLEN-1:2], 2'b00};
      end
      R_STATUS: begin
        status[MIE_BIT]  = csr.csr_rdata[MPIE_BIT];
        status[MPIE_BIT] = 1'b1;
        csr.csr_w     = 1'b1;
        csr.csr_addr  = CSR_MSTATUS;
        csr.csr_wdata = status;
      end
      R_EPC: begin
        csr.csr_addr = CSR_MEPC;
        pc_load      = 1'b1;
        pc_target    = csr.csr_rdata;
      end
      default: ;
    endcase
  end

endmodule
